regfile_write_arbiter: RTL and testbench

//  Owns the single write port of the 32x32 register file (x0 hardwired zero). Shares it

---
 rtl/regfile_write_arbiter_pkg.sv | 19 +
 rtl/regfile_write_arbiter_if.sv | 38 +++
 rtl/regfile_write_arbiter_rr_arbiter2.sv | 40 ++++
 rtl/regfile_write_arbiter.sv | 95 +++++++++
 tb/tb_regfile_write_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared widths, FSM state and requester ids for the write arbiter
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Values match the bit positions in the arbiter req/gnt vectors
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writeback requester and register file write port bundle
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_wdata;
    logic              init_done;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        input  rf_we, rf_rd, rf_wdata, init_done
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        output rf_we, rf_rd, rf_wdata, init_done
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// rtl/regfile_write_arbiter_rr_arbiter2.sv - two-way round-robin arbiter, priority flips only on a handshake
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       fire,
    output logic [1:0] gnt
);

    req_id_e last_grant_q;
    req_id_e last_grant_d;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant_q == REQ_ALU) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (fire) begin
            last_grant_d = gnt[1] ? REQ_MEM : REQ_ALU;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            last_grant_q <= REQ_MEM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register file write port owner: post-reset clear pass, then ALU/MEM round-robin writeback
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W         = REG_DATA_W,
    parameter int ADDR_W         = REG_ADDR_W,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    regfile_write_arbiter_if.slave  bus
);

    state_e            state_q,     state_d;
    logic [ADDR_W-1:0] clr_cnt_q,   clr_cnt_d;
    logic              init_done_q, init_done_d;
    logic              rf_we_q,     rf_we_d;
    logic [ADDR_W-1:0] rf_rd_q,     rf_rd_d;
    logic [DATA_W-1:0] rf_wdata_q,  rf_wdata_d;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       fire;

    // Requests are invisible to the arbiter until the clear pass has finished
    assign req  = {bus.mem_valid, bus.alu_valid} & {2{init_done_q}};
    assign fire = |gnt;

    rr_arbiter2 u_rr_arbiter2 (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .fire    (fire),
        .gnt     (gnt)
    );

    assign bus.alu_ready = gnt[0];
    assign bus.mem_ready = gnt[1];
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_rd     = rf_rd_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.init_done = init_done_q;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        rf_we_d     = 1'b0;
        rf_rd_d     = rf_rd_q;
        rf_wdata_d  = rf_wdata_q;
        case (state_q)
            ST_CLEAR: begin
                rf_we_d    = 1'b1;
                rf_rd_d    = clr_cnt_q;
                rf_wdata_d = '0;
                clr_cnt_d  = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            default: begin
                // x0 is hardwired: the handshake completes but the write is suppressed
                if (gnt[0]) begin
                    rf_we_d    = (bus.alu_rd != '0);
                    rf_rd_d    = bus.alu_rd;
                    rf_wdata_d = bus.alu_data;
                end else if (gnt[1]) begin
                    rf_we_d    = (bus.mem_rd != '0);
                    rf_rd_d    = bus.mem_rd;
                    rf_wdata_d = bus.mem_data;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            init_done_q <= (CLEAR_ON_RESET == 0);
            clr_cnt_q   <= ADDR_W'(1);
            rf_we_q     <= 1'b0;
            rf_rd_q     <= '0;
            rf_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_done_q <= init_done_d;
            clr_cnt_q   <= clr_cnt_d;
            rf_we_q     <= rf_we_d;
            rf_rd_q     <= rf_rd_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic clock;
    logic reset_n;
    int   checks;
    int   failures;

    regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_write_arbiter #(
        .DATA_W         (32),
        .ADDR_W         (5),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_rd    = '0;
        bus.mem_data  = '0;
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        idle_inputs();
        repeat (cycles) tick();
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_rd !== 5'd0 || bus.rf_wdata !== 32'd0 || bus.init_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: we=%b rd=%0d wdata=%h init=%b, need 0/0/0/0",
                     bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.init_done);
        end
        reset_n = 1'b1;
    endtask

    task automatic run_clear();
        repeat (31) tick();
        checks++;
        if (bus.init_done !== 1'b1 || bus.rf_rd !== 5'd31) begin
            failures++;
            $display("FAIL clear_end: init=%b rd=%0d, need 1/31", bus.init_done, bus.rf_rd);
        end
    endtask

    task automatic test_reset();
        do_reset(3);
        bus.alu_valid = 1'b1;
        bus.mem_valid = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            tick();
            checks++;
            if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'(i) || bus.rf_wdata !== 32'd0) begin
                failures++;
                $display("FAIL clear_seq[%0d]: we=%b rd=%0d wdata=%h, need 1/%0d/0",
                         i, bus.rf_we, bus.rf_rd, bus.rf_wdata, i);
            end
            checks++;
            if (bus.init_done !== (i == 31)) begin
                failures++;
                $display("FAIL clear_init[%0d]: init=%b, need %b", i, bus.init_done, (i == 31));
            end
            if (i < 31) begin
                checks++;
                if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL clear_ready[%0d]: alu_ready=%b mem_ready=%b, need 0/0",
                             i, bus.alu_ready, bus.mem_ready);
                end
            end
            if (i == 30) idle_inputs();
        end
        tick();
        checks++;
        if (bus.rf_we !== 1'b0) begin
            failures++;
            $display("FAIL post_clear_idle: we=%b, need 0", bus.rf_we);
        end
    endtask

    task automatic test_single_write();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'hDEADBEEF;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready: alu_ready=%b, need 1", bus.alu_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd5 || bus.rf_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_write: we=%b rd=%0d wdata=%h, need 1/5/deadbeef",
                     bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        tick();
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_rd !== 5'd5 || bus.rf_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_after: we=%b rd=%0d wdata=%h, need 0/5/deadbeef (held)",
                     bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
    endtask

    task automatic test_round_robin();
        logic [4:0]  exp_rd [4] = '{5'd3, 5'd4, 5'd3, 5'd4};
        logic [31:0] exp_wd [4] = '{32'hA, 32'hB, 32'hA, 32'hB};
        do_reset(3);
        run_clear();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_data  = 32'hA;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd4;
        bus.mem_data  = 32'hB;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (bus.alu_ready !== (k % 2 == 0) || bus.mem_ready !== (k % 2 == 1)) begin
                failures++;
                $display("FAIL rr_grant[%0d]: alu_ready=%b mem_ready=%b, need %b/%b",
                         k, bus.alu_ready, bus.mem_ready, (k % 2 == 0), (k % 2 == 1));
            end
            tick();
            checks++;
            if (bus.rf_we !== 1'b1 || bus.rf_rd !== exp_rd[k] || bus.rf_wdata !== exp_wd[k]) begin
                failures++;
                $display("FAIL rr_write[%0d]: we=%b rd=%0d wdata=%h, need 1/%0d/%h",
                         k, bus.rf_we, bus.rf_rd, bus.rf_wdata, exp_rd[k], exp_wd[k]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_rd_zero();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd9;
        bus.alu_data  = 32'h99;
        tick();
        idle_inputs();
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd0;
        bus.mem_data  = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (bus.mem_ready !== 1'b1) begin
            failures++;
            $display("FAIL rd0_ready: mem_ready=%b, need 1", bus.mem_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (bus.rf_we !== 1'b0) begin
            failures++;
            $display("FAIL rd0_we: we=%b, need 0", bus.rf_we);
        end
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd7;
        bus.alu_data  = 32'h1;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 5'd8;
        bus.mem_data  = 32'h2;
        #1;
        checks++;
        if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin
            failures++;
            $display("FAIL rd0_next_grant: alu_ready=%b mem_ready=%b, need 1/0",
                     bus.alu_ready, bus.mem_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd7 || bus.rf_wdata !== 32'h1) begin
            failures++;
            $display("FAIL rd0_next_write: we=%b rd=%0d wdata=%h, need 1/7/1",
                     bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_clear();
        do_reset(1);
        repeat (10) tick();
        checks++;
        if (bus.rf_rd !== 5'd10 || bus.rf_we !== 1'b1) begin
            failures++;
            $display("FAIL midclr_pos: we=%b rd=%0d, need 1/10", bus.rf_we, bus.rf_rd);
        end
        reset_n = 1'b0;
        tick();
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_rd !== 5'd0) begin
            failures++;
            $display("FAIL midclr_reset: we=%b rd=%0d, need 0/0", bus.rf_we, bus.rf_rd);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd1 || bus.init_done !== 1'b0) begin
            failures++;
            $display("FAIL midclr_restart: we=%b rd=%0d init=%b, need 1/1/0",
                     bus.rf_we, bus.rf_rd, bus.init_done);
        end
        repeat (30) tick();
        checks++;
        if (bus.init_done !== 1'b1 || bus.rf_rd !== 5'd31) begin
            failures++;
            $display("FAIL midclr_done: init=%b rd=%0d, need 1/31", bus.init_done, bus.rf_rd);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 5'(i);
            bus.alu_data  = 32'(i * 16);
            #1;
            checks++;
            if (bus.alu_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d]: alu_ready=%b, need 1", i, bus.alu_ready);
            end
            tick();
            checks++;
            if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'(i) || bus.rf_wdata !== 32'(i * 16)) begin
                failures++;
                $display("FAIL b2b_write[%0d]: we=%b rd=%0d wdata=%h, need 1/%0d/%h",
                         i, bus.rf_we, bus.rf_rd, bus.rf_wdata, i, 32'(i * 16));
            end
        end
        idle_inputs();
        tick();
        checks++;
        if (bus.rf_we !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: we=%b, need 0", bus.rf_we);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        idle_inputs();
        tick();
        test_reset();
        test_single_write();
        test_round_robin();
        test_rd_zero();
        test_reset_mid_clear();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
